// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the CPU and VGA masters, the memory arbiter and the
// memory/peripheral bus behind it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_ack;
  logic              vga_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // The arbiter serves both masters and in turn drives the memory bus.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr,
           mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack, cpu_err, vga_rdata, vga_ack, vga_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr,
           mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack, cpu_err, vga_rdata, vga_ack, vga_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single SoC memory port between the CPU and the VGA scan-out reader:
// VGA-priority arbitration, CPU starvation guard and a no-ack timeout watchdog.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CPU_STARVE_MAX = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(CPU_STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS_CPU, BUS_VGA, DONE} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          grant_cpu;
  logic          grant_vga;

  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] c);
    return (c == STARVE_MAX) ? c : c + SW'(1);
  endfunction

  // VGA wins ties until the CPU has been passed over CPU_STARVE_MAX times.
  always_comb begin
    grant_vga = bus.vga_req && !(bus.cpu_req && (starve_cnt == STARVE_MAX));
    grant_cpu = bus.cpu_req && !grant_vga;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= {DATA_W{1'b0}};
      bus.vga_ack   <= 1'b0;
      bus.vga_err   <= 1'b0;
      bus.vga_rdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.cpu_we;
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wdata <= bus.cpu_wdata;
            tmo_cnt       <= '0;
            starve_cnt    <= '0;
            state         <= BUS_CPU;
          end else if (grant_vga) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.vga_addr;
            bus.mem_wdata <= {DATA_W{1'b0}};
            tmo_cnt       <= '0;
            starve_cnt    <= bus.cpu_req ? starve_inc(starve_cnt) : '0;
            state         <= BUS_VGA;
          end else if (!bus.cpu_req) begin
            starve_cnt <= '0;
          end
        end

        // A real mem_ack beats the watchdog when both land on the same cycle.
        BUS_CPU, BUS_VGA: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (bus.mem_ack || (tmo_cnt == TMO_LAST)) begin
            bus.mem_req <= 1'b0;
            state       <= DONE;
            if (state == BUS_CPU) begin
              bus.cpu_ack   <= 1'b1;
              bus.cpu_err   <= !bus.mem_ack;
              bus.cpu_rdata <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : {DATA_W{1'b0}};
            end else begin
              bus.vga_ack   <= 1'b1;
              bus.vga_err   <= !bus.mem_ack;
              bus.vga_rdata <= bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
            end
          end
        end

        // One quiet cycle lets the served master drop its request.
        DONE: begin
          bus.cpu_ack <= 1'b0;
          bus.cpu_err <= 1'b0;
          bus.vga_ack <= 1'b0;
          bus.vga_err <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// two-master run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STARVE = 4;
  localparam int TMO    = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_STARVE_MAX(STARVE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Memory-side environment: acks after mem_wait cycles (or random up to wait_max).
  int   mem_wait   = 0;
  int   wait_max   = 0;
  bit   mem_silent = 0;
  int   inject_req = 0;
  int   inject_done = 0;
  int   cur_wait   = 0;
  int   wcnt       = 0;
  bit   acked      = 0;
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (inject_req != inject_done) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_0BAD;
      inject_done   = inject_req;
    end else if (bus.mem_req === 1'b1 && !acked && !mem_silent) begin
      if (wcnt >= cur_wait) begin
        bus.mem_ack = 1'b1;
        acked       = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata     = $urandom;
        end else begin
          bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : init_word(bus.mem_addr);
        end
      end else begin
        wcnt++;
      end
    end
    if (bus.mem_req !== 1'b1) begin
      acked    = 1'b0;
      wcnt     = 0;
      cur_wait = (wait_max > 0) ? int'($urandom_range(0, wait_max)) : mem_wait;
    end
  end

  task automatic wait_grant(input int limit, output int cyc, output bit got);
    got = 0; cyc = 0;
    while (!got && cyc < limit) begin
      @(posedge clk); #1; cyc++;
      got = (bus.mem_req === 1'b1);
    end
  endtask

  task automatic wait_ack(input bit is_cpu, input int limit, output int cyc, output bit got);
    got = 0; cyc = 0;
    while (!got && cyc < limit) begin
      @(posedge clk); #1; cyc++;
      got = is_cpu ? (bus.cpu_ack === 1'b1) : (bus.vga_ack === 1'b1);
    end
  endtask

  task automatic test_reset();
    int cyc; bit got; bit stray;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 0; bus.vga_addr = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({bus.cpu_rdata, bus.cpu_ack, bus.cpu_err, bus.vga_rdata, bus.vga_ack, bus.vga_err,
         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: mem_req=%b cpu_ack=%b vga_ack=%b mem_addr=%h, required all zero",
                      bus.mem_req, bus.cpu_ack, bus.vga_ack, bus.mem_addr);
    end
    reset = 1'b0;
    mem_silent = 1;
    bus.cpu_we = 1; bus.cpu_addr = 32'h0000_0040; bus.cpu_wdata = 32'h1234_5678; bus.cpu_req = 1;
    @(posedge clk); #1;
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL reset_pre_grant: mem_req=%b required 1", bus.mem_req);
    end
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({bus.mem_req, bus.cpu_ack, bus.vga_ack, bus.cpu_err, bus.vga_err, bus.mem_we} !== 6'b0) begin
      bad++; $display("FAIL reset_async: mem_req=%b cpu_ack=%b vga_ack=%b mem_we=%b, required 0",
                      bus.mem_req, bus.cpu_ack, bus.vga_ack, bus.mem_we);
    end
    bus.cpu_req = 0;
    @(posedge clk); #1;
    reset = 1'b0; mem_silent = 0; mem_wait = 0;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.cpu_ack !== 1'b0 || bus.vga_ack !== 1'b0 || bus.mem_req !== 1'b0) stray = 1;
    end
    total++;
    if (stray) begin
      bad++; $display("FAIL reset_no_ack: activity=%b required 0", stray);
    end
    bus.vga_addr = 32'h8000_0010; bus.vga_req = 1;
    @(posedge clk); #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8000_0010) begin
      bad++; $display("FAIL reset_idle_grant: mem_req=%b mem_addr=%h required 1/80000010",
                      bus.mem_req, bus.mem_addr);
    end
    wait_ack(0, 20, cyc, got);
    bus.vga_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_alone();
    int cyc; bit got; bit stable; int n;
    mem_wait = 2;
    bus.cpu_we = 1; bus.cpu_addr = 32'hB000_0010; bus.cpu_wdata = 32'hDEAD_BEEF; bus.cpu_req = 1;
    wait_grant(5, cyc, got);
    total++;
    if (!got || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'hB000_0010 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL cpu_wr_grant: got=%b we=%b addr=%h wdata=%h required 1/1/b0000010/deadbeef",
                      got, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    n = 0; got = 0; stable = 1;
    while (!got && n < 10) begin
      @(posedge clk); #1; n++;
      got = (bus.cpu_ack === 1'b1);
      if (!got && (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'hB000_0010 ||
                   bus.mem_wdata !== 32'hDEAD_BEEF)) stable = 0;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL cpu_wr_stable: stable=%b required 1", stable);
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL cpu_wr_latency: cycles=%0d required 3", n);
    end
    total++;
    if (bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.vga_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL cpu_wr_ack: err=%b rdata=%h vga_ack=%b mem_req=%b required 0/0/0/0",
                      bus.cpu_err, bus.cpu_rdata, bus.vga_ack, bus.mem_req);
    end
    bus.cpu_req = 0;
    @(posedge clk); #1;
    total++;
    if (bus.cpu_ack !== 1'b0) begin
      bad++; $display("FAIL cpu_ack_pulse: cpu_ack=%b required 0", bus.cpu_ack);
    end
    mem_wait = 0;
    bus.cpu_we = 0; bus.cpu_wdata = '0; bus.cpu_req = 1;
    wait_grant(5, cyc, got);
    wait_ack(1, 20, cyc, got);
    total++;
    if (!got || bus.cpu_rdata !== 32'hDEAD_BEEF || bus.cpu_err !== 1'b0) begin
      bad++; $display("FAIL cpu_readback: got=%b rdata=%h err=%b required 1/deadbeef/0",
                      got, bus.cpu_rdata, bus.cpu_err);
    end
    bus.cpu_req = 0;
    repeat (2) @(posedge clk); #1;
    total++;
    if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL cpu_rdata_hold: rdata=%h required deadbeef", bus.cpu_rdata);
    end
  endtask

  task automatic test_contention();
    int n; int cyc; bit prev; bit exp_c;
    mem_wait = 0;
    bus.cpu_we = 0; bus.cpu_addr = 32'h0000_0100; bus.vga_addr = 32'h8000_0040;
    bus.cpu_req = 1; bus.vga_req = 1;
    n = 0; cyc = 0; prev = 0;
    while (n < 15 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (bus.mem_req === 1'b1 && !prev) begin
        exp_c = ((n % 5) == 4);
        total++;
        if ((!bus.mem_addr[31]) !== exp_c) begin
          bad++; $display("FAIL contention_grant[%0d]: cpu_won=%b required %b", n, !bus.mem_addr[31], exp_c);
        end
        n++;
      end
      prev = (bus.mem_req === 1'b1);
    end
    total++;
    if (n != 15) begin
      bad++; $display("FAIL contention_count: grants=%0d required 15", n);
    end
    bus.cpu_req = 0; bus.vga_req = 0;
    repeat (8) @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cyc; bit got; bit stray;
    mem_silent = 1;
    bus.vga_addr = 32'h8000_0100; bus.vga_req = 1;
    wait_grant(5, cyc, got);
    wait_ack(0, TMO + 20, cyc, got);
    total++;
    if (!got || cyc != TMO) begin
      bad++; $display("FAIL tmo_latency: got=%b cycles=%0d required %0d", got, cyc, TMO);
    end
    total++;
    if (bus.vga_err !== 1'b1 || bus.vga_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL tmo_flags: err=%b rdata=%h mem_req=%b required 1/0/0",
                      bus.vga_err, bus.vga_rdata, bus.mem_req);
    end
    bus.vga_req = 0; mem_silent = 0;
    inject_req++;
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.cpu_ack === 1'b1 || bus.vga_ack === 1'b1 || bus.mem_req === 1'b1) stray = 1;
    end
    total++;
    if (stray) begin
      bad++; $display("FAIL tmo_late_ack: activity=%b required 0", stray);
    end
    bus.cpu_we = 0; bus.cpu_addr = 32'h0000_0200; bus.cpu_req = 1;
    wait_grant(5, cyc, got);
    wait_ack(1, 20, cyc, got);
    total++;
    if (!got || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== init_word(32'h0000_0200)) begin
      bad++; $display("FAIL tmo_recover: got=%b err=%b rdata=%h required 1/0/%h",
                      got, bus.cpu_err, bus.cpu_rdata, init_word(32'h0000_0200));
    end
    bus.cpu_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_late_drop();
    int cyc; bit got; bit stray;
    mem_wait = 3;
    bus.cpu_we = 0; bus.cpu_addr = 32'h0000_0300; bus.cpu_req = 1;
    wait_grant(5, cyc, got);
    @(posedge clk); #1;
    bus.cpu_req = 0;
    wait_ack(1, 20, cyc, got);
    total++;
    if (!got || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== init_word(32'h0000_0300)) begin
      bad++; $display("FAIL drop_completes: got=%b err=%b rdata=%h required 1/0/%h",
                      got, bus.cpu_err, bus.cpu_rdata, init_word(32'h0000_0300));
    end
    mem_wait = 0;
    repeat (3) @(posedge clk); #1;
    inject_req++;
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.cpu_ack === 1'b1 || bus.vga_ack === 1'b1 || bus.mem_req === 1'b1) stray = 1;
    end
    total++;
    if (stray) begin
      bad++; $display("FAIL idle_stray_ack: activity=%b required 0", stray);
    end
  endtask

  task automatic test_same_cycle();
    int cyc; bit got;
    mem_wait = TMO - 1;
    bus.vga_addr = 32'h8000_0200; bus.vga_req = 1;
    wait_grant(5, cyc, got);
    wait_ack(0, TMO + 20, cyc, got);
    total++;
    if (!got || cyc != TMO || bus.vga_err !== 1'b0 || bus.vga_rdata !== init_word(32'h8000_0200)) begin
      bad++; $display("FAIL edge_ack: got=%b cycles=%0d err=%b rdata=%h required 1/%0d/0/%h",
                      got, cyc, bus.vga_err, bus.vga_rdata, TMO, init_word(32'h8000_0200));
    end
    bus.vga_req = 0; mem_wait = 0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_random();
    int c_gap, v_gap, owner, age, vga_wins, grants, acks;
    logic [31:0] g_addr, g_wdata, exp_rd;
    logic g_we;
    bit prev_req, prev_cack, prev_vack, exp_cpu, act_cpu;
    wait_max = 4;
    bus.cpu_req = 0; bus.vga_req = 0;
    c_gap = 1; v_gap = 0; owner = 0; age = 0; vga_wins = 0; grants = 0; acks = 0;
    prev_req = 0; prev_cack = 0; prev_vack = 0;
    g_addr = '0; g_wdata = '0; g_we = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (bus.mem_req === 1'b1 && !prev_req) begin
        exp_cpu = bus.cpu_req && (!bus.vga_req || vga_wins >= STARVE);
        act_cpu = !bus.mem_addr[31];
        total++;
        if (act_cpu !== exp_cpu || owner != 0) begin
          bad++; $display("FAIL rnd_grant: cpu_won=%b owner=%0d required %b/0", act_cpu, owner, exp_cpu);
        end
        total++;
        if (act_cpu) begin
          if (bus.mem_we !== bus.cpu_we || bus.mem_addr !== bus.cpu_addr || bus.mem_wdata !== bus.cpu_wdata) begin
            bad++; $display("FAIL rnd_cpu_fields: we=%b addr=%h wdata=%h required %b/%h/%h",
                            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata);
          end
          vga_wins = 0; owner = 1;
        end else begin
          if (bus.mem_we !== 1'b0 || bus.mem_addr !== bus.vga_addr || bus.mem_wdata !== 32'h0) begin
            bad++; $display("FAIL rnd_vga_fields: we=%b addr=%h wdata=%h required 0/%h/0",
                            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.vga_addr);
          end
          if (bus.cpu_req) vga_wins++;
          owner = 2;
        end
        g_addr = bus.mem_addr; g_we = bus.mem_we; g_wdata = bus.mem_wdata; age = 0; grants++;
      end else if (bus.mem_req === 1'b1) begin
        age++;
        total++;
        if (bus.mem_addr !== g_addr || bus.mem_we !== g_we || bus.mem_wdata !== g_wdata || age > 20) begin
          bad++; $display("FAIL rnd_hold: addr=%h we=%b age=%0d required %h/%b/<=20",
                          bus.mem_addr, bus.mem_we, age, g_addr, g_we);
        end
      end
      if (bus.cpu_ack === 1'b1 || bus.vga_ack === 1'b1) begin
        exp_rd = g_we ? 32'h0 : (ref_mem.exists(g_addr) ? ref_mem[g_addr] : init_word(g_addr));
        total++;
        if (bus.cpu_ack === 1'b1 && bus.vga_ack === 1'b1) begin
          bad++; $display("FAIL rnd_double_ack: cpu_ack=1 vga_ack=1 required one");
        end else if (bus.cpu_ack === 1'b1) begin
          if (owner != 1 || prev_cack || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== exp_rd || bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL rnd_cpu_ack: owner=%0d err=%b rdata=%h required 1/0/%h",
                            owner, bus.cpu_err, bus.cpu_rdata, exp_rd);
          end
          if (g_we) ref_mem[g_addr] = g_wdata;
          owner = 0; bus.cpu_req = 0; c_gap = $urandom_range(0, 3); acks++;
        end else begin
          if (owner != 2 || prev_vack || bus.vga_err !== 1'b0 || bus.vga_rdata !== exp_rd || bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL rnd_vga_ack: owner=%0d err=%b rdata=%h required 2/0/%h",
                            owner, bus.vga_err, bus.vga_rdata, exp_rd);
          end
          owner = 0; bus.vga_req = 0; v_gap = $urandom_range(0, 3); acks++;
        end
      end
      prev_req  = (bus.mem_req === 1'b1);
      prev_cack = (bus.cpu_ack === 1'b1);
      prev_vack = (bus.vga_ack === 1'b1);
      if (!bus.cpu_req && owner != 1) begin
        if (c_gap == 0) begin
          bus.cpu_we    = 1'($urandom_range(0, 1));
          bus.cpu_addr  = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7));
          bus.cpu_wdata = $urandom;
          bus.cpu_req   = 1;
          vga_wins      = 0;
        end else c_gap--;
      end
      if (!bus.vga_req && owner != 2) begin
        if (v_gap == 0) begin
          bus.vga_addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7));
          bus.vga_req  = 1;
        end else v_gap--;
      end
    end
    total++;
    if (grants < 100 || acks < 100) begin
      bad++; $display("FAIL rnd_activity: grants=%0d acks=%0d required >=100", grants, acks);
    end
    bus.cpu_req = 0; bus.vga_req = 0; wait_max = 0;
    repeat (20) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_cpu_alone();
    test_contention();
    test_timeout();
    test_late_drop();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
